// File: rtl/sig_pkg.sv
// Shared types and defaults for the audio sample storer: capture and
// write state encodings, default sizing and the sample packing helper.
package sig_pkg;

   // Capture side: waiting for start, for the low sample, for the high sample.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2
   } cap_state_t;

   // Write side: nothing pending, request pulse, waiting for acknowledge.
   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_REQ  = 2'd1,
      W_WAIT = 2'd2
   } wr_state_t;

   localparam int unsigned SAMPLES_DEFAULT   = 32'd512;
   localparam int unsigned ADDR_STEP_DEFAULT = 32'd4;
   localparam int unsigned CNT_W             = 32'd10;

   // First sample of a pair occupies the low half of the word.
   function automatic logic [31:0] pack_pair(input logic [15:0] lo_sample,
                                             input logic [15:0] hi_sample);
      return {hi_sample, lo_sample};
   endfunction

endpackage

// File: rtl/sig_storer_if.sv
// Bundle of control, DMA master and audio stream signals of sig_storer.
// The slave modport is the storer's view, master is the driving side.
interface sig_storer_if;
   logic        start;
   logic [31:0] start_addr_write;
   logic [31:0] dma1_addr;
   logic        dma1_read;
   logic        dma1_write;
   logic [31:0] dma1_writedata;
   logic [31:0] dma_readdata;
   logic        dma_rdy;
   logic [15:0] audio_data;
   logic        audio_valid;
   logic        audio_rdy;
   logic        busy;
   logic        done;

   modport slave (
      input  start,
      input  start_addr_write,
      input  dma_readdata,
      input  dma_rdy,
      input  audio_data,
      input  audio_valid,
      output dma1_addr,
      output dma1_read,
      output dma1_write,
      output dma1_writedata,
      output audio_rdy,
      output busy,
      output done
   );

   modport master (
      output start,
      output start_addr_write,
      output dma_readdata,
      output dma_rdy,
      output audio_data,
      output audio_valid,
      input  dma1_addr,
      input  dma1_read,
      input  dma1_write,
      input  dma1_writedata,
      input  audio_rdy,
      input  busy,
      input  done
   );
endinterface

// File: rtl/sig_word_buf.sv
// Single-entry holding register for a packed 32-bit word plus its
// occupied flag. A load wins over a simultaneous drain so a word that
// arrives in the acknowledge cycle is kept.
module sig_word_buf (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        load,
   input  logic [31:0] load_data,
   input  logic        drain,
   output logic        full,
   output logic [31:0] data
);

   logic        full_r;
   logic [31:0] data_r;

   // Occupancy flag and stored word: clear on new capture, load, or drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_r <= 1'b0;
         data_r <= 32'd0;
      end else if (clr) begin
         full_r <= 1'b0;
         data_r <= 32'd0;
      end else if (load) begin
         full_r <= 1'b1;
         data_r <= load_data;
      end else if (drain) begin
         full_r <= 1'b0;
      end
   end

   assign full = full_r;
   assign data = data_r;

endmodule

// File: rtl/sig_storer.sv
// Captures SAMPLES 16-bit audio samples, packs pairs into 32-bit words and
// writes them out through a single-word DMA write port. Capture of the next
// pair overlaps the outstanding write of the previous word. SAMPLES must be
// even and within 2..1022 so the 10-bit sample counter can reach it.
module sig_storer
   import sig_pkg::*;
#(
   parameter int unsigned SAMPLES   = SAMPLES_DEFAULT,
   parameter int unsigned ADDR_STEP = ADDR_STEP_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   sig_storer_if.slave  bus
);

   localparam logic [CNT_W-1:0] SAMPLES_C = CNT_W'(SAMPLES);
   localparam logic [31:0]      STEP_C    = 32'(ADDR_STEP);

   cap_state_t       cap_state_r;
   cap_state_t       cap_state_s;
   wr_state_t        w_state_r;
   wr_state_t        w_state_s;

   logic [CNT_W-1:0] cnt_r;
   logic [15:0]      pack_r;
   logic [31:0]      addr_r;

   logic             busy_r;
   logic             done_r;
   logic             dma1_write_r;
   logic [31:0]      dma1_addr_r;
   logic [31:0]      dma1_writedata_r;

   logic             start_acc_s;
   logic             all_in_s;
   logic             drain_s;
   logic             audio_rdy_s;
   logic             xfer_s;
   logic             lo_xfer_s;
   logic             hi_xfer_s;
   logic             final_ack_s;
   logic             buf_full_s;
   logic [31:0]      buf_data_s;
   logic             unused_readdata_s;

   // The read data port of the DMA master is not used by a write-only client.
   assign unused_readdata_s = ^bus.dma_readdata;

   assign start_acc_s = (cap_state_r == IDLE) && bus.start;
   assign all_in_s    = (cnt_r == SAMPLES_C);
   assign drain_s     = (w_state_r == W_WAIT) && bus.dma_rdy;
   assign xfer_s      = bus.audio_valid && audio_rdy_s;
   assign lo_xfer_s   = xfer_s && (cap_state_r == LO);
   assign hi_xfer_s   = xfer_s && (cap_state_r == HI);
   // Once every sample is in, the only word that can still be acknowledged
   // is the last one, so any acknowledge then ends the capture.
   assign final_ack_s = drain_s && all_in_s && (cap_state_r != IDLE);

   // Sample acceptance: open for the low half, and for the high half only
   // when the word buffer has room now or frees up this very cycle.
   always_comb begin
      audio_rdy_s = 1'b0;
      case (cap_state_r)
         IDLE: audio_rdy_s = 1'b0;
         LO:   audio_rdy_s = !all_in_s;
         HI:   audio_rdy_s = !all_in_s && (!buf_full_s || drain_s);
         default: audio_rdy_s = 1'b0;
      endcase
   end

   // Capture FSM next state.
   always_comb begin
      cap_state_s = cap_state_r;
      case (cap_state_r)
         IDLE: begin
            if (bus.start) begin
               cap_state_s = LO;
            end else begin
               cap_state_s = IDLE;
            end
         end
         LO: begin
            if (final_ack_s) begin
               cap_state_s = IDLE;
            end else if (lo_xfer_s) begin
               cap_state_s = HI;
            end else begin
               cap_state_s = LO;
            end
         end
         HI: begin
            if (hi_xfer_s) begin
               cap_state_s = LO;
            end else begin
               cap_state_s = HI;
            end
         end
         default: cap_state_s = IDLE;
      endcase
   end

   // Write FSM next state.
   always_comb begin
      w_state_s = w_state_r;
      case (w_state_r)
         W_IDLE: begin
            if (buf_full_s) begin
               w_state_s = W_REQ;
            end else begin
               w_state_s = W_IDLE;
            end
         end
         W_REQ: w_state_s = W_WAIT;
         W_WAIT: begin
            if (bus.dma_rdy) begin
               w_state_s = W_IDLE;
            end else begin
               w_state_s = W_WAIT;
            end
         end
         default: w_state_s = W_IDLE;
      endcase
   end

   // State registers for both FSMs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_state_r <= IDLE;
         w_state_r   <= W_IDLE;
      end else begin
         cap_state_r <= cap_state_s;
         w_state_r   <= w_state_s;
      end
   end

   // Sample counter, low-half pack register and running write address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r  <= {CNT_W{1'b0}};
         pack_r <= 16'd0;
         addr_r <= 32'd0;
      end else if (start_acc_s) begin
         cnt_r  <= {CNT_W{1'b0}};
         pack_r <= 16'd0;
         addr_r <= bus.start_addr_write;
      end else begin
         if (xfer_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
         if (lo_xfer_s) begin
            pack_r <= bus.audio_data;
         end
         if (drain_s) begin
            addr_r <= addr_r + STEP_C;
         end
      end
   end

   sig_word_buf u_word_buf (
      .clk       (clk),
      .rst       (rst),
      .clr       (start_acc_s),
      .load      (hi_xfer_s),
      .load_data (pack_pair(pack_r, bus.audio_data)),
      .drain     (drain_s),
      .full      (buf_full_s),
      .data      (buf_data_s)
   );

   // Registered status and DMA request outputs; request fields are zero
   // whenever the write FSM is not presenting a request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r           <= 1'b0;
         done_r           <= 1'b0;
         dma1_write_r     <= 1'b0;
         dma1_addr_r      <= 32'd0;
         dma1_writedata_r <= 32'd0;
      end else begin
         if (start_acc_s) begin
            busy_r <= 1'b1;
         end else if (final_ack_s) begin
            busy_r <= 1'b0;
         end
         done_r <= final_ack_s;
         if (w_state_s == W_REQ) begin
            dma1_write_r     <= 1'b1;
            dma1_addr_r      <= addr_r;
            dma1_writedata_r <= buf_data_s;
         end else begin
            dma1_write_r     <= 1'b0;
            dma1_addr_r      <= 32'd0;
            dma1_writedata_r <= 32'd0;
         end
      end
   end

   assign bus.dma1_read      = 1'b0;
   assign bus.dma1_write     = dma1_write_r;
   assign bus.dma1_addr      = dma1_addr_r;
   assign bus.dma1_writedata = dma1_writedata_r;
   assign bus.audio_rdy      = audio_rdy_s;
   assign bus.busy           = busy_r;
   assign bus.done           = done_r;

endmodule
